echo_delay: RTL and testbench
=============================

Name: echo_delay

Overview:
- Audio effect stage directly downstream of the ADC SPI front end in the pedal signal chain.
- Takes each 12-bit offset-binary ADC sample as it is strobed valid and converts it to signed form.
- Adds a scaled, feedback-delayed copy of past output from a circular sample buffer, saturates the result and emits a 12-bit offset-binary sample for the output (DAC/PWM) stage.

Parameters:
- DATA_W, 12: sample width, matches ADC resolution.
- ADDR_W, 10: buffer address width; depth = 2^ADDR_W samples.

Ports:
- clk, input, 1: system clock; all logic on posedge.
- reset, input, 1: synchronous, active-high reset.
- in_valid, input, 1: one-cycle strobe; in_data holds a new sample.
- in_data, input, DATA_W: ADC sample, unsigned offset-binary (2048 = zero).
- delay_len, input, ADDR_W: echo delay in samples; sampled on accept.
- mix, input, 4: feedback gain in 1/16 steps (0..15); sampled on accept.
- bypass, input, 1: 1 = pass dry input to output; sampled on accept.
- out_valid, output, 1: one-cycle strobe; out_data is valid.
- out_data, output, DATA_W: processed sample, offset-binary.
- busy, output, 1: high while a sample is in flight (states RD..WR).
- overrun, output, 1: sticky flag; a sample arrived while busy.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, wr_ptr=0, fill=0, out_valid=0, out_data=12'h800, busy=0, overrun=0.
- Buffer RAM contents are not reset. The fill counter masks stale data instead.
- FSM states: IDLE, RD, CALC, WR.
- IDLE: on in_valid, perform the following, then go to RD.
  - Latch x = {~in_data[11], in_data[10:0]} (signed).
  - Latch delay_len, mix and bypass.
  - Issue a synchronous RAM read at raddr = wr_ptr - delay_len (mod 2^ADDR_W).
- RD: RAM data returns (1-cycle read latency). Go to CALC.
- CALC: compute the following, then go to WR.
  - d = RAM data, forced to 0 if delay_len==0 or fill < delay_len.
  - p = d * mix, signed 16-bit; s = p >>> 4 (arithmetic shift, floor).
  - y = sat12(x + s), where the sum is 13-bit and sat12 clamps to [-2048, 2047].
- WR: perform the following, then go to IDLE.
  - Write y to RAM[wr_ptr]. If bypass, write x instead.
  - wr_ptr <= wr_ptr+1; wraps 2^ADDR_W-1 -> 0.
  - fill <= fill+1, saturating at 2^ADDR_W-1.
  - out_data <= bypass ? in_data (latched) : {~y[11], y[10:0]}.
  - out_valid <= 1 for exactly one cycle.
- Latency: in_valid at cycle T gives out_valid high at cycle T+4. Back-to-back acceptance is possible every 4 cycles.
- in_valid while busy=1 (states RD..WR): the sample is dropped and overrun sets. It clears only on reset. The in-flight sample is unaffected.
- in_valid in the same cycle the FSM returns to IDLE (the out_valid cycle) is accepted.
- mix=0: output equals input exactly; the buffer still stores y (= x).
- delay_len=0: no echo (d=0).
- Changes to delay_len, mix or bypass mid-flight have no effect until the next accept.
- Reset asserted mid-operation: the FSM aborts to IDLE and no out_valid is emitted for the aborted sample. The partial RAM write is permitted but is masked because fill=0.

Test Plan:
- Reset, then in_data=12'hA00, delay_len=4, mix=8 -> out_valid 4 cycles later, out_data=12'hA00 (fill masks echo); busy high for 3 cycles; overrun=0.
- Samples 12'hC00 then 12'h800 x4, delay_len=4, mix=8, one every 16 cycles -> 5th output = 12'h800 + (0x400*8>>4) = 12'hA00.
- Saturation: in_data=12'hFFF with stored delayed +2047 and mix=15 -> out_data=12'hFFF; same test with negatives -> 12'h000.
- Overrun: in_valid at T and T+2 -> one out_valid at T+4, overrun=1 and held; in_valid exactly at T+4 is accepted and not flagged.
- Bypass=1, mix=15, nonzero echo history -> out_data equals in_data each sample; after bypass=0, echo reflects stored dry samples.
- Wrap: ADDR_W=3, delay_len=7, drive 20 samples -> wr_ptr wraps 7->0; the echo tap always references the sample 7 samples earlier; fill saturates at 7.

Source files
------------

// File: rtl/echo_delay_if.sv
`default_nettype none
// ============================================================================
//  Module      : echo_delay_if
//  Description : Sample-stream bundle between the ADC front end, the echo
//                stage and the output (DAC/PWM) stage.
//  Revision    : 1.0 - initial release
// ============================================================================
interface echo_delay_if #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic [ADDR_W-1:0] delay_len;
    logic [3:0]        mix;
    logic              bypass;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              busy;
    logic              overrun;

    // Upstream side: supplies samples and settings, observes results.
    modport master (
        output in_valid, in_data, delay_len, mix, bypass,
        input  out_valid, out_data, busy, overrun
    );

    // Echo stage side.
    modport slave (
        input  in_valid, in_data, delay_len, mix, bypass,
        output out_valid, out_data, busy, overrun
    );
endinterface
`default_nettype wire

// File: rtl/echo_delay.sv
`default_nettype none
// ============================================================================
//  Module      : echo_delay
//  Description : Feedback echo stage. Each accepted offset-binary sample is
//                mixed with a scaled copy of the output stored delay_len
//                samples earlier, saturated, stored and emitted.
//  Revision    : 1.0 - initial release
// ============================================================================
module echo_delay #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 10
) (
    input  logic         clk,
    input  logic         reset,
    echo_delay_if.slave  bus
);
    localparam int c_DEPTH = 1 << ADDR_W;
    localparam int c_PW    = DATA_W + 4;

    localparam logic [DATA_W-1:0]        c_ZERO_OB = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [ADDR_W-1:0]        c_FILL_MAX = '1;
    localparam logic signed [c_PW-1:0]   c_SAT_HI = c_PW'((1 << (DATA_W-1)) - 1);
    localparam logic signed [c_PW-1:0]   c_SAT_LO = -c_PW'(1 << (DATA_W-1));
    localparam logic signed [DATA_W-1:0] c_Y_HI = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] c_Y_LO = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_CALC = 2'd2,
        S_WR   = 2'd3
    } state_t;

    state_t                    r_state;
    logic [DATA_W-1:0]         r_mem [c_DEPTH];
    logic [ADDR_W-1:0]         r_wr_ptr;
    logic [ADDR_W-1:0]         r_fill;
    logic [ADDR_W-1:0]         r_delay;
    logic [3:0]                r_mix;
    logic                      r_bypass;
    logic signed [DATA_W-1:0]  r_x;
    logic [DATA_W-1:0]         r_in_raw;
    logic signed [DATA_W-1:0]  r_rdata;
    logic signed [DATA_W-1:0]  r_y;
    logic                      r_out_valid;
    logic [DATA_W-1:0]         r_out_data;
    logic                      r_busy;
    logic                      r_overrun;

    logic [ADDR_W-1:0]         w_raddr;
    logic signed [DATA_W-1:0]  w_d;
    logic signed [c_PW-1:0]    w_p;
    logic signed [c_PW-1:0]    w_s;
    logic signed [c_PW-1:0]    w_sum;
    logic signed [DATA_W-1:0]  w_y;

    // Echo tap address, delayed sample masking, scaling and saturation.
    always_comb begin
        w_raddr = r_wr_ptr - bus.delay_len;
        // Entries not yet written since reset hold stale data; treat as silence.
        w_d     = (r_delay == '0 || r_fill < r_delay) ? '0 : r_rdata;
        w_p     = $signed({{4{w_d[DATA_W-1]}}, w_d}) * $signed({{DATA_W{1'b0}}, r_mix});
        w_s     = w_p >>> 4;
        w_sum   = $signed({{4{r_x[DATA_W-1]}}, r_x}) + w_s;
        if (w_sum > c_SAT_HI) begin
            w_y = c_Y_HI;
        end else if (w_sum < c_SAT_LO) begin
            w_y = c_Y_LO;
        end else begin
            w_y = w_sum[DATA_W-1:0];
        end
    end

    // Delay buffer: registered read at accept, write-back of the stored sample.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && bus.in_valid) begin
            r_rdata <= r_mem[w_raddr];
        end
        if (r_state == S_WR) begin
            r_mem[r_wr_ptr] <= r_bypass ? r_x : r_y;
        end
    end

    // Sample sequencer: accept, wait for RAM, compute, write back and emit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= '0;
            r_fill      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= c_ZERO_OB;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_x      <= {~bus.in_data[DATA_W-1], bus.in_data[DATA_W-2:0]};
                        r_in_raw <= bus.in_data;
                        r_delay  <= bus.delay_len;
                        r_mix    <= bus.mix;
                        r_bypass <= bus.bypass;
                        r_busy   <= 1'b1;
                        r_state  <= S_RD;
                    end
                end
                S_RD: begin
                    r_state <= S_CALC;
                end
                S_CALC: begin
                    r_y     <= w_y;
                    r_state <= S_WR;
                end
                S_WR: begin
                    r_wr_ptr    <= r_wr_ptr + 1'b1;
                    if (r_fill != c_FILL_MAX) begin
                        r_fill <= r_fill + 1'b1;
                    end
                    r_out_data  <= r_bypass ? r_in_raw : {~r_y[DATA_W-1], r_y[DATA_W-2:0]};
                    r_out_valid <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
            // A sample arriving while one is in flight is lost; remember it.
            if (r_state != S_IDLE && bus.in_valid) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.busy      = r_busy;
    assign bus.overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_echo_delay.sv
`default_nettype none
// ============================================================================
//  Module      : tb_echo_delay
//  Description : Self-checking bench for echo_delay. Instance 0 uses the
//                default 1024-deep buffer, instance 1 an 8-deep buffer to
//                exercise pointer wrap and fill saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_echo_delay;
    logic        clk;
    logic [1:0]  rst;
    logic [1:0]  iv;
    logic [11:0] idata [2];
    logic [9:0]  dl    [2];
    logic [3:0]  mx    [2];
    logic [1:0]  byp;
    logic [1:0]  ov;
    logic [11:0] od    [2];
    logic [1:0]  bsy;
    logic [1:0]  ovr_o;

    echo_delay_if #(.DATA_W(12), .ADDR_W(10)) bus0 ();
    echo_delay_if #(.DATA_W(12), .ADDR_W(3))  bus1 ();

    assign bus0.in_valid  = iv[0];
    assign bus0.in_data   = idata[0];
    assign bus0.delay_len = dl[0];
    assign bus0.mix       = mx[0];
    assign bus0.bypass    = byp[0];
    assign bus1.in_valid  = iv[1];
    assign bus1.in_data   = idata[1];
    assign bus1.delay_len = dl[1][2:0];
    assign bus1.mix       = mx[1];
    assign bus1.bypass    = byp[1];
    assign ov[0]    = bus0.out_valid;
    assign ov[1]    = bus1.out_valid;
    assign od[0]    = bus0.out_data;
    assign od[1]    = bus1.out_data;
    assign bsy[0]   = bus0.busy;
    assign bsy[1]   = bus1.busy;
    assign ovr_o[0] = bus0.overrun;
    assign ovr_o[1] = bus1.overrun;

    echo_delay #(.DATA_W(12), .ADDR_W(10)) dut0 (.clk(clk), .reset(rst[0]), .bus(bus0));
    echo_delay #(.DATA_W(12), .ADDR_W(3))  dut1 (.clk(clk), .reset(rst[1]), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int inst, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s[%0d] @%0t: got 0x%0h, expected 0x%0h", name, inst, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int cyc = 0;
    int started [2] = '{0, 0};
    int was_rst [2] = '{0, 0};
    int acc     [2] = '{-100, -100};
    int m_ovr   [2] = '{0, 0};
    int nsamp   [2] = '{0, 0};
    int exp_out [2] = '{0, 0};
    int hist    [2][0:4095];

    function automatic int floor16(input int p);
        return (p >= 0) ? p / 16 : -((-p + 15) / 16);
    endfunction

    function automatic int sat12(input int v);
        return (v > 2047) ? 2047 : (v < -2048) ? -2048 : v;
    endfunction

    task automatic model_step(input int i);
        int x, dlv, d, y;
        if (rst[i]) begin
            started[i] = 1;
            was_rst[i] = 1;
            acc[i]     = -100;
            m_ovr[i]   = 0;
            nsamp[i]   = 0;
        end else begin
            was_rst[i] = 0;
            if (iv[i]) begin
                if (cyc < acc[i] + 4) begin
                    m_ovr[i] = 1;
                end else begin
                    acc[i] = cyc;
                    x   = int'(idata[i]) - 2048;
                    dlv = (i == 0) ? int'(dl[i]) : int'(dl[i]) & 7;
                    d   = (dlv == 0 || nsamp[i] < dlv) ? 0 : hist[i][nsamp[i] - dlv];
                    y   = sat12(x + floor16(d * int'(mx[i])));
                    hist[i][nsamp[i]] = byp[i] ? x : y;
                    nsamp[i]++;
                    exp_out[i] = byp[i] ? int'(idata[i]) : y + 2048;
                end
            end
        end
    endtask

    task automatic check_outputs(input int i);
        int e_ov, e_busy;
        e_ov   = (!was_rst[i] && cyc == acc[i] + 3) ? 1 : 0;
        e_busy = (!was_rst[i] && cyc >= acc[i] && cyc <= acc[i] + 2) ? 1 : 0;
        check("out_valid", i, int'(ov[i]), e_ov);
        if (e_ov == 1 && ov[i]) check("out_data", i, int'(od[i]), exp_out[i]);
        if (was_rst[i]) check("reset_out_data", i, int'(od[i]), 'h800);
        check("busy", i, int'(bsy[i]), e_busy);
        check("overrun", i, int'(ovr_o[i]), m_ovr[i]);
    endtask

    // Per-cycle compare against the model, sampled 1 time unit after the edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            for (int i = 0; i < 2; i++) model_step(i);
            #1;
            for (int i = 0; i < 2; i++) if (started[i] != 0) check_outputs(i);
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int i);
        @(negedge clk); rst[i] = 1'b1;
        @(negedge clk); rst[i] = 1'b0;
    endtask

    // Drives one sample, scrambles settings while it is in flight, waits for
    // the result and (if exp >= 0) checks it against a literal.
    task automatic send(input int i, input logic [11:0] data, input int dlen,
                        input int mixv, input bit bypv, input int exp, input int gap);
        bit got;
        @(negedge clk);
        idata[i] = data; dl[i] = 10'(dlen); mx[i] = 4'(mixv); byp[i] = bypv; iv[i] = 1'b1;
        @(negedge clk);
        iv[i] = 1'b0;
        idata[i] = 12'($urandom); dl[i] = 10'($urandom); mx[i] = 4'($urandom); byp[i] = 1'($urandom);
        got = 0;
        for (int k = 0; k < 6; k++) begin
            if (ov[i]) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            check("out_timeout", i, 0, 1);
        end else if (exp >= 0) begin
            check("literal_out", i, int'(od[i]), exp);
        end
        idle(gap);
    endtask

    initial begin
        rst = 2'b11; iv = 2'b00; byp = 2'b00;
        for (int i = 0; i < 2; i++) begin
            idata[i] = 12'h800; dl[i] = '0; mx[i] = '0;
        end
        idle(3);
        rst = 2'b00;
        idle(2);

        // First sample after reset: echo masked by empty buffer.
        send(0, 12'hA00, 4, 8, 0, 'hA00, 2);

        // Single impulse followed by silence; the fifth output carries the echo.
        do_reset(0);
        send(0, 12'hC00, 4, 8, 0, 'hC00, 11);
        for (int k = 0; k < 3; k++) send(0, 12'h800, 4, 8, 0, 'h800, 11);
        send(0, 12'h800, 4, 8, 0, 'hA00, 11);

        // Zero delay means no echo even at full gain.
        send(0, 12'h900, 0, 15, 0, 'h900, 1);

        // Arithmetic shift floors negative products: -1 * 1 / 16 -> -1.
        send(0, 12'h7FF, 1, 0, 0, 'h7FF, 1);
        send(0, 12'h800, 1, 1, 0, 'h7FF, 1);

        // Saturation at both rails.
        send(0, 12'hFFF, 1, 0, 0, 'hFFF, 1);
        send(0, 12'hFFF, 1, 15, 0, 'hFFF, 1);
        send(0, 12'h000, 1, 0, 0, 'h000, 1);
        send(0, 12'h000, 1, 15, 0, 'h000, 1);

        // Bypass passes the dry sample and stores it for later echoes.
        send(0, 12'hB00, 1, 15, 0, -1, 1);
        send(0, 12'h300, 1, 15, 1, 'h300, 1);
        send(0, 12'h500, 1, 15, 1, 'h500, 1);
        send(0, 12'h800, 1, 8, 0, 'h680, 2);

        // Overrun: second strobe two cycles after accept is dropped; a strobe
        // on the out_valid cycle is accepted.
        do_reset(0);
        @(negedge clk); idata[0] = 12'hA00; dl[0] = 10'd4; mx[0] = 4'd8; byp[0] = 1'b0; iv[0] = 1'b1;
        @(negedge clk); iv[0] = 1'b0;
        @(negedge clk); idata[0] = 12'h400; iv[0] = 1'b1;
        @(negedge clk); iv[0] = 1'b0;
        @(negedge clk);
        check("ovr_out_valid", 0, int'(ov[0]), 1);
        check("ovr_out_data", 0, int'(od[0]), 'hA00);
        idata[0] = 12'h900; dl[0] = 10'd1; mx[0] = 4'd8; iv[0] = 1'b1;
        @(negedge clk); iv[0] = 1'b0;
        check("ovr_sticky", 0, int'(ovr_o[0]), 1);
        idle(2);
        @(negedge clk);
        check("ovr_second_out", 0, int'(od[0]), 'hA00);
        idle(3);

        // Reset mid-flight aborts the sample; the next sample sees no echo.
        do_reset(0);
        @(negedge clk); idata[0] = 12'hB00; dl[0] = 10'd1; mx[0] = 4'd15; iv[0] = 1'b1;
        @(negedge clk); iv[0] = 1'b0;
        @(negedge clk); rst[0] = 1'b1;
        @(negedge clk); rst[0] = 1'b0;
        idle(6);
        send(0, 12'h900, 1, 15, 0, 'h900, 2);

        // Small buffer: pointer wrap, fill saturation, 7-sample tap.
        do_reset(1);
        send(1, 12'hC00, 7, 8, 0, 'hC00, 0);
        for (int k = 0; k < 6; k++) send(1, 12'h800, 7, 8, 0, 'h800, 0);
        send(1, 12'h800, 7, 8, 0, 'hA00, 0);
        for (int k = 0; k < 12; k++) send(1, 12'($urandom), 7, int'($urandom_range(0, 15)), 0, -1, 0);
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
